imem_loadable: RTL and testbench

//  Parametrised instruction memory with registered (1-cycle) fetch, a streaming program-load

---
 rtl/imem_loadable.sv | 122 ++++++++++++
 tb/tb_imem_loadable.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Instruction memory with a registered fetch port, a streaming program-load port and a
// post-reset hardware clear. Fetches beyond DEPTH return a NOP and raise addr_fault.
module imem_loadable #(
  parameter int    DATA_W     = 16,
  parameter int    ADDR_W     = 16,
  parameter int    DEPTH      = 1024,
  parameter bit    INIT_CLEAR = 1'b1,
  parameter string MEM_FILE   = "",
  localparam int   CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [CNT_W-1:0]  ld_count,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;
  localparam state_t RESET_STATE = INIT_CLEAR ? CLEAR : IDLE;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic fetch_fire, ld_fire, load_end, base_oob, fetch_oob, mem_we;
  logic [DATA_W-1:0] mem_wdata;

  // fetch_ready/ld_ready are registered copies of "next state is IDLE/LOAD",
  // so they double as the state qualifiers for acceptance.
  assign fetch_fire = fetch_req && fetch_ready;
  assign ld_fire    = ld_valid && ld_ready;
  assign load_end   = ld_fire && (ld_last || ptr == LAST_ADDR);
  assign base_oob   = {1'b0, ld_base} >= DEPTH_EXT;
  assign fetch_oob  = {1'b0, fetch_addr} >= DEPTH_EXT;
  assign mem_we     = !rst && (state == CLEAR || ld_fire);
  assign mem_wdata  = (state == CLEAR) ? '0 : ld_data;

  // Power-up image; CLEAR overwrites it when INIT_CLEAR is set.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      CLEAR:   if (ptr == LAST_ADDR) state_next = IDLE;
      IDLE:    if (ld_start && !base_oob) state_next = LOAD;
      LOAD:    if (load_end) state_next = IDLE;
      default: state_next = RESET_STATE;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; clearing it is the job of CLEAR.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr[IDX_W-1:0]] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
      ld_done     <= 1'b0;
      ld_count    <= '0;
      fetch_ready <= 1'b0;
      ld_ready    <= 1'b0;
      busy        <= INIT_CLEAR;
    end else begin
      instr_valid <= fetch_fire;
      ld_done     <= 1'b0;
      if (fetch_fire) begin
        instr      <= fetch_oob ? '0 : mem[fetch_addr[IDX_W-1:0]];
        addr_fault <= fetch_oob;
      end
      case (state)
        CLEAR: ptr <= ptr + ADDR_W'(1);
        IDLE: begin
          if (ld_start) begin
            ld_count <= '0;
            if (base_oob) ld_done <= 1'b1;
            else          ptr     <= ld_base;
          end
        end
        LOAD: begin
          if (ld_fire) begin
            ptr      <= ptr + ADDR_W'(1);
            ld_count <= ld_count + CNT_W'(1);
            if (load_end) ld_done <= 1'b1;
          end
        end
        default: ;
      endcase
      fetch_ready <= (state_next == IDLE);
      ld_ready    <= (state_next == LOAD);
      busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed sequences, a fetch vector table and
// randomized load/fetch traffic compared against a plain array model of the memory.
module tb_imem_loadable;

  localparam int DEPTH = 1024;
  localparam int CNT_W = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ready;
  logic [15:0] instr;
  logic        instr_valid;
  logic        addr_fault;
  logic        ld_start;
  logic [15:0] ld_base;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic [CNT_W-1:0] ld_count;
  logic        busy;

  imem_loadable dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp_instr;
    logic        exp_fault;
  } fvec_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] beats [$];
  fvec_t       tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    return (addr < DEPTH) ? ref_mem[addr[9:0]] : 16'h0000;
  endfunction

  // Reset, check the reset state, then count the busy cycles of the clear sequence.
  task automatic do_reset(input string tag);
    int n;
    rst = 1'b1;
    step();
    step();
    check({tag, " rst busy"}, busy, 1);
    check({tag, " rst fetch_ready"}, fetch_ready, 0);
    check({tag, " rst ld_ready"}, ld_ready, 0);
    check({tag, " rst instr_valid"}, instr_valid, 0);
    check({tag, " rst instr"}, instr, 0);
    check({tag, " rst ld_done"}, ld_done, 0);
    check({tag, " rst ld_count"}, ld_count, 0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 3000);
    check({tag, " clear cycles"}, n, DEPTH);
    check({tag, " ready after clear"}, fetch_ready, 1);
  endtask

  task automatic do_fetch(input logic [15:0] addr, input string tag);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    step();
    fetch_req = 1'b0;
    check({tag, " valid"}, instr_valid, 1);
    check({tag, " instr"}, instr, model_read(addr));
    check({tag, " fault"}, addr_fault, addr >= DEPTH);
  endtask

  // Runs one load session with the beats queue; co_fetch >= 0 issues a fetch with ld_start.
  task automatic do_load(input logic [15:0] base, input int last_at, input int co_fetch,
                         input string tag);
    int          cnt;
    bit          done;
    int          a;
    logic [15:0] co_exp;
    cnt  = 0;
    done = 1'b0;
    ld_start = 1'b1;
    ld_base  = base;
    if (co_fetch >= 0) begin
      fetch_req  = 1'b1;
      fetch_addr = co_fetch[15:0];
      co_exp     = model_read(co_fetch[15:0]);
    end
    step();
    ld_start  = 1'b0;
    fetch_req = 1'b0;
    if (co_fetch >= 0) begin
      check({tag, " cofetch valid"}, instr_valid, 1);
      check({tag, " cofetch instr"}, instr, co_exp);
    end
    if (base >= DEPTH) begin
      check({tag, " oob ld_done"}, ld_done, 1);
      check({tag, " oob ld_count"}, ld_count, 0);
      check({tag, " oob ld_ready"}, ld_ready, 0);
      step();
      check({tag, " oob done pulse"}, ld_done, 0);
      check({tag, " oob fetch_ready"}, fetch_ready, 1);
      return;
    end
    check({tag, " start ld_ready"}, ld_ready, 1);
    check({tag, " start fetch_ready"}, fetch_ready, 0);
    check({tag, " start ld_count"}, ld_count, 0);
    for (int i = 0; i < beats.size() && !done; i++) begin
      repeat ($urandom_range(0, 2)) step();
      ld_valid   = 1'b1;
      ld_data    = beats[i];
      ld_last    = (i == last_at);
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = 16'($urandom_range(0, 1023));
      step();
      ld_valid  = 1'b0;
      ld_last   = 1'b0;
      fetch_req = 1'b0;
      a = int'(base) + i;
      ref_mem[a] = beats[i];
      cnt++;
      check({tag, " fetch blocked"}, instr_valid, 0);
      if (i == last_at || a == DEPTH - 1) begin
        done = 1'b1;
        check({tag, " ld_done"}, ld_done, 1);
        check({tag, " ld_count"}, ld_count, cnt);
        check({tag, " end ld_ready"}, ld_ready, 0);
        check({tag, " end fetch_ready"}, fetch_ready, 1);
        step();
        check({tag, " done pulse"}, ld_done, 0);
        check({tag, " count hold"}, ld_count, cnt);
      end else begin
        check({tag, " mid ld_done"}, ld_done, 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'd2,    16'h1590, 1'b0};
    tbl[1] = '{16'd3,    16'h1902, 1'b0};
    tbl[2] = '{16'd0,    16'h0001, 1'b0};
    tbl[3] = '{16'd1,    16'h0100, 1'b0};
    tbl[4] = '{16'd1024, 16'h0000, 1'b1};
    tbl[5] = '{16'd1,    16'h0100, 1'b0};
    tbl[6] = '{16'hFFFF, 16'h0000, 1'b1};
    tbl[7] = '{16'd1023, 16'h0000, 1'b0};

    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; ld_start = 1'b0; ld_base = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // T1: clear sequence, then every word reads back as zero.
    do_reset("t1");
    for (int i = 0; i < DEPTH; i++) do_fetch(16'(i), "t1 sweep");

    // T2: four-beat load from address 0.
    beats = '{16'h0001, 16'h0100, 16'h1590, 16'h1902};
    do_load(16'd0, 3, -1, "t2");

    // T2/T4: fetch vector table, including out-of-range addresses.
    for (int i = 0; i < 8; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = tbl[i].addr;
      step();
      fetch_req = 1'b0;
      check($sformatf("tbl%0d valid", i), instr_valid, 1);
      check($sformatf("tbl%0d instr", i), instr, tbl[i].exp_instr);
      check($sformatf("tbl%0d fault", i), addr_fault, tbl[i].exp_fault);
    end

    // T3: back-to-back fetches, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 16'(i);
      step();
      check($sformatf("t3 valid%0d", i), instr_valid, 1);
      check($sformatf("t3 instr%0d", i), instr, model_read(16'(i)));
    end
    fetch_req = 1'b0;
    step();
    check("hold valid", instr_valid, 0);
    check("hold instr", instr, 16'h1902);

    // T5: load running off the top of memory without ld_last.
    beats = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    do_load(16'd1022, -1, -1, "t5");
    do_fetch(16'd1022, "t5 rd1022");
    do_fetch(16'd1023, "t5 rd1023");

    // Load session starting out of range.
    do_load(16'd2000, -1, -1, "oob");

    // Fetch served in the same cycle as ld_start.
    beats = '{16'hBEEF, 16'hCAFE};
    do_load(16'd10, 1, 3, "co");
    do_fetch(16'd10, "co rd10");
    do_fetch(16'd11, "co rd11");

    // T6: reset after two of four beats wipes the partial load.
    beats = '{16'h1111, 16'h2222};
    do_load(16'd0, -1, -1, "t6");
    do_reset("t6");
    do_fetch(16'd0, "t6 rd0");
    do_fetch(16'd1, "t6 rd1");

    // Randomized traffic against the array model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        int base, len, last_at;
        base    = $urandom_range(0, 1100);
        len     = $urandom_range(1, 8);
        last_at = int'($urandom_range(0, len)) - 1;
        if (last_at < 0 && base + len < DEPTH) last_at = len - 1;
        beats.delete();
        for (int b = 0; b < len; b++) beats.push_back(16'($urandom));
        do_load(16'(base), last_at, -1, "rnd load");
      end else begin
        int n;
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          logic [15:0] ad;
          ad = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
          do_fetch(ad, "rnd fetch");
          if ($urandom_range(0, 1) == 1) step();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
